// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one multi-cycle memory between the
// I-cache refill port (0) and the D-cache port (1), with a per-access watchdog.
module mem_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r1_req,
    input  logic              r0_wen,
    input  logic              r1_wen,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r0_wdata,
    input  logic [31:0]       r1_wdata,
    input  logic [3:0]        r0_bsel,
    input  logic [3:0]        r1_bsel,
    output logic              r0_ack,
    output logic              r1_ack,
    output logic              r0_err,
    output logic              r1_err,
    output logic [31:0]       r0_rdata,
    output logic [31:0]       r1_rdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [3:0]        mem_bsel,
    input  logic [31:0]       mem_dout,
    input  logic              mem_ack,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    // Requester fields gathered into port-indexed vectors.
    logic [1:0]             req_vec;
    logic [1:0]             wen_vec;
    logic [1:0][ADDR_W-1:0] addr_vec;
    logic [1:0][31:0]       wdata_vec;
    logic [1:0][3:0]        bsel_vec;

    assign req_vec   = {r1_req, r0_req};
    assign wen_vec   = {r1_wen, r0_wen};
    assign addr_vec  = {r1_addr, r0_addr};
    assign wdata_vec = {r1_wdata, r0_wdata};
    assign bsel_vec  = {r1_bsel, r0_bsel};

    state_t            state_reg, state_next;
    logic              ptr_reg, ptr_next;
    logic [1:0]        grant_reg, grant_next;
    logic              ren_reg, ren_next;
    logic              wen_reg, wen_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       din_reg, din_next;
    logic [3:0]        bsel_reg, bsel_next;
    logic [7:0]        wdog_reg, wdog_next;
    logic [1:0]        ack_reg, ack_next;
    logic [1:0]        err_reg, err_next;
    logic [1:0][31:0]  rdata_reg, rdata_next;

    logic pick;
    logic win;

    // Under contention the pointer decides; otherwise the lone requester wins.
    assign pick = (req_vec[0] && req_vec[1]) ? ptr_reg : req_vec[1];
    assign win  = grant_reg[1];

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        ren_next   = ren_reg;
        wen_next   = wen_reg;
        addr_next  = addr_reg;
        din_next   = din_reg;
        bsel_next  = bsel_reg;
        wdog_next  = wdog_reg;
        ack_next   = 2'b00;
        err_next   = 2'b00;
        rdata_next = rdata_reg;

        case (state_reg)
            S_IDLE: begin
                if (|req_vec) begin
                    grant_next = pick ? 2'b10 : 2'b01;
                    ren_next   = !wen_vec[pick];
                    wen_next   = wen_vec[pick];
                    addr_next  = addr_vec[pick];
                    din_next   = wdata_vec[pick];
                    bsel_next  = bsel_vec[pick];
                    wdog_next  = 8'd0;
                    ptr_next   = !pick;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                // A memory ack in the final watchdog cycle still counts as success.
                if (mem_ack) begin
                    if (ren_reg) begin
                        rdata_next[win] = mem_dout;
                    end
                    ack_next[win] = 1'b1;
                    ren_next      = 1'b0;
                    wen_next      = 1'b0;
                    state_next    = S_DONE;
                end else if (wdog_reg == WDOG_LAST) begin
                    ack_next[win]   = 1'b1;
                    err_next[win]   = 1'b1;
                    rdata_next[win] = 32'd0;
                    ren_next        = 1'b0;
                    wen_next        = 1'b0;
                    state_next      = S_DONE;
                end else begin
                    wdog_next = wdog_reg + 8'd1;
                end
            end
            S_DONE: begin
                grant_next = 2'b00;
                state_next = S_IDLE;
            end
            default: begin
                grant_next = 2'b00;
                ren_next   = 1'b0;
                wen_next   = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            ptr_reg   <= 1'b0;
            grant_reg <= 2'b00;
            ren_reg   <= 1'b0;
            wen_reg   <= 1'b0;
            addr_reg  <= '0;
            din_reg   <= 32'd0;
            bsel_reg  <= 4'd0;
            wdog_reg  <= 8'd0;
            ack_reg   <= 2'b00;
            err_reg   <= 2'b00;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            ren_reg   <= ren_next;
            wen_reg   <= wen_next;
            addr_reg  <= addr_next;
            din_reg   <= din_next;
            bsel_reg  <= bsel_next;
            wdog_reg  <= wdog_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            rdata_reg <= rdata_next;
        end
    end

    assign r0_ack   = ack_reg[0];
    assign r1_ack   = ack_reg[1];
    assign r0_err   = err_reg[0];
    assign r1_err   = err_reg[1];
    assign r0_rdata = rdata_reg[0];
    assign r1_rdata = rdata_reg[1];
    assign mem_ren  = ren_reg;
    assign mem_wen  = wen_reg;
    assign mem_addr = addr_reg;
    assign mem_din  = din_reg;
    assign mem_bsel = bsel_reg;
    assign grant    = grant_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small multi-cycle memory model whose
// ack delay (strobe cycles until mem_ack; 0 = never) is set per scenario.
module tb_mem_arbiter;

    localparam int ADDR_W  = 14;
    localparam int TIMEOUT = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              r0_req = 1'b0, r1_req = 1'b0;
    logic              r0_wen = 1'b0, r1_wen = 1'b0;
    logic [ADDR_W-1:0] r0_addr = '0, r1_addr = '0;
    logic [31:0]       r0_wdata = 32'd0, r1_wdata = 32'd0;
    logic [3:0]        r0_bsel = 4'hF, r1_bsel = 4'hF;
    logic              r0_ack, r1_ack, r0_err, r1_err;
    logic [31:0]       r0_rdata, r1_rdata;
    logic              mem_ren, mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [3:0]        mem_bsel;
    logic [31:0]       mem_dout = 32'hA5A5A5A5;
    logic              mem_ack = 1'b0;
    logic [1:0]        grant;

    int checks = 0;
    int passes = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r1_req(r1_req),
        .r0_wen(r0_wen), .r1_wen(r1_wen),
        .r0_addr(r0_addr), .r1_addr(r1_addr),
        .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_bsel(r0_bsel), .r1_bsel(r1_bsel),
        .r0_ack(r0_ack), .r1_ack(r1_ack),
        .r0_err(r0_err), .r1_err(r1_err),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_bsel(mem_bsel),
        .mem_dout(mem_dout), .mem_ack(mem_ack),
        .grant(grant)
    );

    always #5 clock = ~clock;

    // Memory model: counts strobe cycles, acks in strobe cycle ack_delay.
    logic [31:0] mem [0:255];
    int          ack_delay = 0;
    int          scnt = 0;
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = 8'd0;
    logic [31:0] pre_data = 32'd0;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(negedge clock) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (mem_ren || mem_wen) begin
            scnt <= scnt + 1;
            if (ack_delay != 0 && scnt + 1 == ack_delay) begin
                mem_ack  <= 1'b1;
                mem_dout <= mem_ren ? mem[mem_addr[7:0]] : 32'hA5A5A5A5;
                if (mem_wen) mem[mem_addr[7:0]] <= merge(mem[mem_addr[7:0]], mem_din, mem_bsel);
            end else begin
                mem_ack  <= 1'b0;
                mem_dout <= 32'hA5A5A5A5;
            end
        end else begin
            scnt     <= 0;
            mem_ack  <= 1'b0;
            mem_dout <= 32'hA5A5A5A5;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clock);
        #1;
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b expected 00", grant); else passes++;
        checks++; if ({mem_ren, mem_wen} !== 2'b00) $display("FAIL reset_strobes: got %b expected 00", {mem_ren, mem_wen}); else passes++;
        checks++; if ({r0_ack, r1_ack, r0_err, r1_err} !== 4'b0000) $display("FAIL reset_ack_err: got %b expected 0000", {r0_ack, r1_ack, r0_err, r1_err}); else passes++;
        checks++; if (r0_rdata !== 32'd0) $display("FAIL reset_r0_rdata: got %h expected 0", r0_rdata); else passes++;
        checks++; if (r1_rdata !== 32'd0) $display("FAIL reset_r1_rdata: got %h expected 0", r1_rdata); else passes++;
        checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); else passes++;
        checks++; if (mem_din !== 32'd0) $display("FAIL reset_mem_din: got %h expected 0", mem_din); else passes++;
        checks++; if (mem_bsel !== 4'd0) $display("FAIL reset_mem_bsel: got %b expected 0000", mem_bsel); else passes++;
        reset = 1'b0;
        repeat (2) tick();
        checks++; if (grant !== 2'b00) $display("FAIL idle_grant: got %b expected 00", grant); else passes++;
        $display("reset: outputs cleared");
    endtask

    task automatic test_single_read();
        int ren_cyc = 0, bad_addr = 0, acks = 0, r1acks = 0, errs = 0, ack_cyc = 0;
        preload(8'h05, 32'hDEADBEEF);
        ack_delay = 8;
        r0_wen = 1'b0; r0_addr = 14'h0005; r0_req = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (mem_ren) begin ren_cyc++; if (mem_addr !== 14'h0005) bad_addr++; end
            if (r0_ack) begin acks++; ack_cyc = c; r0_req = 1'b0; end
            if (r0_err) errs++;
            if (r1_ack) r1acks++;
        end
        checks++; if (ren_cyc != 8) $display("FAIL read_ren_cycles: got %0d expected 8", ren_cyc); else passes++;
        checks++; if (bad_addr != 0) $display("FAIL read_mem_addr: got %0d bad cycles expected 0", bad_addr); else passes++;
        checks++; if (acks != 1) $display("FAIL read_ack_count: got %0d expected 1", acks); else passes++;
        checks++; if (ack_cyc != 9) $display("FAIL read_ack_cycle: got %0d expected 9", ack_cyc); else passes++;
        checks++; if (errs != 0) $display("FAIL read_err: got %0d expected 0", errs); else passes++;
        checks++; if (r0_rdata !== 32'hDEADBEEF) $display("FAIL read_rdata: got %h expected deadbeef", r0_rdata); else passes++;
        checks++; if (r1acks != 0) $display("FAIL read_r1_ack: got %0d expected 0", r1acks); else passes++;
        $display("r0 read  addr 0005 data %h", r0_rdata);
    endtask

    task automatic test_byte_write();
        int wen_cyc = 0, bad = 0, ren_bad = 0, acks = 0, r0acks = 0, errs = 0;
        preload(8'h10, 32'hAABBCCDD);
        ack_delay = 3;
        r1_wen = 1'b1; r1_addr = 14'h0010; r1_wdata = 32'h11223344; r1_bsel = 4'b0101; r1_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (mem_wen) begin
                wen_cyc++;
                if (mem_bsel !== 4'b0101 || mem_din !== 32'h11223344 || mem_addr !== 14'h0010) bad++;
            end
            if (mem_ren) ren_bad++;
            if (r1_ack) begin acks++; r1_req = 1'b0; r1_wen = 1'b0; end
            if (r1_err) errs++;
            if (r0_ack) r0acks++;
        end
        checks++; if (wen_cyc != 3) $display("FAIL write_wen_cycles: got %0d expected 3", wen_cyc); else passes++;
        checks++; if (bad != 0) $display("FAIL write_command: got %0d bad cycles expected 0", bad); else passes++;
        checks++; if (ren_bad != 0) $display("FAIL write_ren: got %0d expected 0", ren_bad); else passes++;
        checks++; if (acks != 1) $display("FAIL write_ack_count: got %0d expected 1", acks); else passes++;
        checks++; if (errs != 0) $display("FAIL write_err: got %0d expected 0", errs); else passes++;
        checks++; if (r1_rdata !== 32'd0) $display("FAIL write_r1_rdata: got %h expected 0", r1_rdata); else passes++;
        checks++; if (r0acks != 0) $display("FAIL write_r0_ack: got %0d expected 0", r0acks); else passes++;
        checks++; if (r0_rdata !== 32'hDEADBEEF) $display("FAIL write_r0_rdata: got %h expected deadbeef", r0_rdata); else passes++;
        checks++; if (mem[8'h10] !== 32'hAA22CC44) $display("FAIL write_mem_word: got %h expected aa22cc44", mem[8'h10]); else passes++;
        $display("r1 write addr 0010 data 11223344 bsel 0101");
    endtask

    task automatic test_contention();
        int acks = 0, bad_onehot = 0, both = 0, nogrant = 0;
        int order [4];
        logic re0 = 1'b0, re1 = 1'b0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        reset = 1'b1; tick(); reset = 1'b0; tick();
        ack_delay = 1;
        r0_wen = 1'b0; r0_addr = 14'h0005;
        r1_wen = 1'b0; r1_addr = 14'h0010;
        r0_req = 1'b1; r1_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (re0) begin r0_req = 1'b1; re0 = 1'b0; end
            if (re1) begin r1_req = 1'b1; re1 = 1'b0; end
            if (grant !== 2'b00 && grant !== 2'b01 && grant !== 2'b10) bad_onehot++;
            if (mem_ren && mem_wen) both++;
            if ((mem_ren || mem_wen) && grant === 2'b00) nogrant++;
            if (r0_ack) begin
                if (acks < 4) order[acks] = 0;
                acks++; r0_req = 1'b0; if (acks <= 2) re0 = 1'b1;
                $display("r0 read  addr 0005 data %h", r0_rdata);
            end
            if (r1_ack) begin
                if (acks < 4) order[acks] = 1;
                acks++; r1_req = 1'b0; if (acks <= 2) re1 = 1'b1;
                $display("r1 read  addr 0010 data %h", r1_rdata);
            end
        end
        checks++; if (acks != 4) $display("FAIL cont_ack_count: got %0d expected 4", acks); else passes++;
        checks++; if (order[0] != 0) $display("FAIL cont_order0: got %0d expected 0", order[0]); else passes++;
        checks++; if (order[1] != 1) $display("FAIL cont_order1: got %0d expected 1", order[1]); else passes++;
        checks++; if (order[2] != 0) $display("FAIL cont_order2: got %0d expected 0", order[2]); else passes++;
        checks++; if (order[3] != 1) $display("FAIL cont_order3: got %0d expected 1", order[3]); else passes++;
        checks++; if (bad_onehot != 0) $display("FAIL cont_onehot: got %0d bad cycles expected 0", bad_onehot); else passes++;
        checks++; if (both != 0) $display("FAIL cont_both_strobes: got %0d cycles expected 0", both); else passes++;
        checks++; if (nogrant != 0) $display("FAIL cont_strobe_no_grant: got %0d cycles expected 0", nogrant); else passes++;
        checks++; if (r1_rdata !== 32'hAA22CC44) $display("FAIL cont_r1_rdata: got %h expected aa22cc44", r1_rdata); else passes++;
    endtask

    task automatic test_timeout();
        int stb = 0, acks = 0, errs = 0, err_on_ack = 0, ack_cyc = 0, r1acks = 0;
        int acks1 = 0, errs1 = 0;
        preload(8'h40, 32'hCAFE0001);
        ack_delay = 0;
        r0_wen = 1'b0; r0_addr = 14'h0005; r0_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (mem_ren || mem_wen) stb++;
            if (r0_err) errs++;
            if (r1_ack) r1acks++;
            if (r0_ack) begin
                acks++; ack_cyc = c; r0_req = 1'b0;
                if (r0_err) err_on_ack++;
            end
        end
        checks++; if (stb != 16) $display("FAIL tmo_strobe_cycles: got %0d expected 16", stb); else passes++;
        checks++; if (acks != 1) $display("FAIL tmo_ack_count: got %0d expected 1", acks); else passes++;
        checks++; if (ack_cyc != 17) $display("FAIL tmo_ack_cycle: got %0d expected 17", ack_cyc); else passes++;
        checks++; if (errs != 1 || err_on_ack != 1) $display("FAIL tmo_err: got %0d/%0d expected 1/1", errs, err_on_ack); else passes++;
        checks++; if (r0_rdata !== 32'd0) $display("FAIL tmo_rdata: got %h expected 0", r0_rdata); else passes++;
        checks++; if (r1acks != 0) $display("FAIL tmo_r1_ack: got %0d expected 0", r1acks); else passes++;
        $display("r0 read  addr 0005 timeout rdata %h", r0_rdata);

        ack_delay = 2;
        r1_wen = 1'b0; r1_addr = 14'h0040; r1_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (r1_err) errs1++;
            if (r1_ack) begin acks1++; r1_req = 1'b0; end
        end
        checks++; if (acks1 != 1) $display("FAIL tmo_next_ack: got %0d expected 1", acks1); else passes++;
        checks++; if (errs1 != 0) $display("FAIL tmo_next_err: got %0d expected 0", errs1); else passes++;
        checks++; if (r1_rdata !== 32'hCAFE0001) $display("FAIL tmo_next_rdata: got %h expected cafe0001", r1_rdata); else passes++;
        $display("r1 read  addr 0040 data %h", r1_rdata);
    endtask

    task automatic test_ack_boundary();
        int stb = 0, acks = 0, errs = 0, ack_cyc = 0;
        preload(8'h20, 32'h0BADF00D);
        ack_delay = 16;
        r1_wen = 1'b0; r1_addr = 14'h0020; r1_req = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (mem_ren) stb++;
            if (r1_err) errs++;
            if (r1_ack) begin acks++; ack_cyc = c; r1_req = 1'b0; end
        end
        checks++; if (stb != 16) $display("FAIL bnd_strobe_cycles: got %0d expected 16", stb); else passes++;
        checks++; if (acks != 1 || ack_cyc != 17) $display("FAIL bnd_ack: got %0d at cycle %0d expected 1 at 17", acks, ack_cyc); else passes++;
        checks++; if (errs != 0) $display("FAIL bnd_err: got %0d expected 0", errs); else passes++;
        checks++; if (r1_rdata !== 32'h0BADF00D) $display("FAIL bnd_rdata: got %h expected 0badf00d", r1_rdata); else passes++;
        $display("r1 read  addr 0020 data %h", r1_rdata);
    endtask

    task automatic test_reset_mid_access();
        int r1acks = 0, r0acks = 0;
        logic [1:0] first_grant = 2'b00;
        preload(8'h30, 32'h12345678);
        ack_delay = 0;
        r1_wen = 1'b1; r1_addr = 14'h0030; r1_wdata = 32'hFFFFFFFF; r1_bsel = 4'hF; r1_req = 1'b1;
        repeat (3) tick();
        checks++; if (mem_wen !== 1'b1) $display("FAIL rst_pre_wen: got %b expected 1", mem_wen); else passes++;
        reset = 1'b1;
        #1;
        checks++; if ({mem_ren, mem_wen} !== 2'b00) $display("FAIL rst_strobes: got %b expected 00", {mem_ren, mem_wen}); else passes++;
        checks++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b expected 00", grant); else passes++;
        checks++; if ({r0_ack, r1_ack} !== 2'b00) $display("FAIL rst_acks: got %b expected 00", {r0_ack, r1_ack}); else passes++;
        checks++; if (r1_rdata !== 32'd0) $display("FAIL rst_r1_rdata: got %h expected 0", r1_rdata); else passes++;
        r1_req = 1'b0; r1_wen = 1'b0;
        tick();
        reset = 1'b0;
        ack_delay = 2;
        r0_wen = 1'b0; r0_addr = 14'h0005; r0_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (first_grant === 2'b00 && grant !== 2'b00) first_grant = grant;
            if (r1_ack) r1acks++;
            if (r0_ack) begin r0acks++; r0_req = 1'b0; end
        end
        checks++; if (first_grant !== 2'b01) $display("FAIL rst_first_grant: got %b expected 01", first_grant); else passes++;
        checks++; if (r1acks != 0) $display("FAIL rst_spurious_r1_ack: got %0d expected 0", r1acks); else passes++;
        checks++; if (r0acks != 1) $display("FAIL rst_r0_ack: got %0d expected 1", r0acks); else passes++;
        checks++; if (r0_rdata !== 32'hDEADBEEF) $display("FAIL rst_r0_rdata: got %h expected deadbeef", r0_rdata); else passes++;
        checks++; if (mem[8'h30] !== 32'h12345678) $display("FAIL rst_mem_untouched: got %h expected 12345678", mem[8'h30]); else passes++;
        $display("r1 write addr 0030 aborted by reset; r0 read addr 0005 data %h", r0_rdata);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_byte_write();
        test_contention();
        test_timeout();
        test_ack_boundary();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
